// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction fetch stage: default instruction
// memory address width, the NOP encoding shown to decode while nothing valid
// is presented, and the 2-bit fetch FSM state encoding.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

   localparam int          IM_ADDR_WIDTH = 8;
   localparam logic [31:0] NOP_ENCODING  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // first cycle after reset release
      ST_RUN   = 2'd1,   // streaming one fetch per cycle
      ST_STALL = 2'd2    // decode is stalled, fetch is parked
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's bus-side signals:
//   - decode side  : stall_i in, inst_o/pc_o/valid_o out
//   - execute side : branch_taken_i/branchtarget_i in
//   - imem side    : im_en_o/im_addr_o out, im_data_i in
// master = the fetch stage, slave = its environment (decode/execute/imem).
// -----------------------------------------------------------------------------
interface fetch_stage_if
   import fetch_stage_pkg::*;
#(
   parameter int IM_AW = IM_ADDR_WIDTH
);

   logic             stall_i;
   logic             branch_taken_i;
   logic [IM_AW-1:0] branchtarget_i;
   logic             im_en_o;
   logic [IM_AW-1:0] im_addr_o;
   logic [31:0]      im_data_i;
   logic [31:0]      inst_o;
   logic [IM_AW-1:0] pc_o;
   logic             valid_o;

   modport master (
      input  stall_i, branch_taken_i, branchtarget_i, im_data_i,
      output im_en_o, im_addr_o, inst_o, pc_o, valid_o
   );

   modport slave (
      output stall_i, branch_taken_i, branchtarget_i, im_data_i,
      input  im_en_o, im_addr_o, inst_o, pc_o, valid_o
   );

endinterface

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry buffer holding an instruction word and its address. Catches the
// read that was already in flight when decode stalled, so it can be replayed
// when the stall drops.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   load_i         capture word_i/pc_i, set valid
//   clear_i        drop the entry (wins over load_i)
//   word_i, pc_i   data to capture
//   valid_o        entry holds a word
//   word_o, pc_o   stored word and its address
// -----------------------------------------------------------------------------
module fetch_skid_buf
   import fetch_stage_pkg::*;
#(
   parameter int IM_AW = IM_ADDR_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic [31:0]      word_i,
   input  logic [IM_AW-1:0] pc_i,
   output logic             valid_o,
   output logic [31:0]      word_o,
   output logic [IM_AW-1:0] pc_o
);

   logic             valid_d, valid_q;
   logic [31:0]      word_d,  word_q;
   logic [IM_AW-1:0] pc_d,    pc_q;

   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      pc_d    = pc_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         word_d  = word_i;
         pc_d    = pc_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) valid_q <= 1'b0;
      else      valid_q <= valid_d;
   end

   // NOTE: the payload is deliberately left without reset, like a storage
   // array; valid_q alone says whether its contents mean anything.
   always_ff @(posedge clk) begin
      word_q <= word_d;
      pc_q   <= pc_d;
   end

   assign valid_o = valid_q;
   assign word_o  = word_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage feeding decode. Generates the PC, drives a
// synchronous-read instruction memory (1-cycle latency) and registers the
// returned word into inst_o/pc_o/valid_o. A decode stall parks the read that
// was in flight in a one-entry skid buffer; a taken branch from execute
// redirects fetch and squashes everything younger.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  fetch_stage_if.master: stall_i, branch_taken_i, branchtarget_i,
//        im_en_o, im_addr_o (combinational), im_data_i, inst_o, pc_o, valid_o
// -----------------------------------------------------------------------------
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int               IM_AW    = IM_ADDR_WIDTH,
   parameter logic [IM_AW-1:0] RESET_PC = '0,
   parameter logic [31:0]      NOP_INST = NOP_ENCODING
) (
   input  logic              clk,
   input  logic              rst,
   fetch_stage_if.master     bus
);

   localparam logic [IM_AW-1:0] PC_ONE = {{(IM_AW-1){1'b0}}, 1'b1};

   fetch_state_e     state_d, state_q;
   logic [IM_AW-1:0] pc_d, pc_q;               // next sequential fetch address
   logic             pending_d, pending_q;     // a read is in flight
   logic [IM_AW-1:0] pending_pc_d, pending_pc_q;
   logic [31:0]      inst_d, inst_q;
   logic [IM_AW-1:0] pc_out_d, pc_out_q;
   logic             valid_d, valid_q;

   logic             issue;                    // sequential fetch at pc_q
   logic             im_en;
   logic [IM_AW-1:0] im_addr;
   logic             skid_load, skid_clear, skid_valid;
   logic [31:0]      skid_word;
   logic [IM_AW-1:0] skid_pc;

   fetch_skid_buf #(.IM_AW(IM_AW)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .word_i  (bus.im_data_i),
      .pc_i    (pending_pc_q),
      .valid_o (skid_valid),
      .word_o  (skid_word),
      .pc_o    (skid_pc)
   );

   // NOTE: every signal assigned here gets a default on entry, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pending_d    = pending_q;
      pending_pc_d = pending_pc_q;
      inst_d       = inst_q;
      pc_out_d     = pc_out_q;
      valid_d      = valid_q;
      issue        = 1'b0;
      im_en        = 1'b0;
      im_addr      = pc_q;
      skid_load    = 1'b0;
      skid_clear   = 1'b0;

      if (bus.branch_taken_i) begin
         // Redirect beats stall: the target read is issued now, whatever was
         // in flight or parked is younger than the branch and is dropped.
         im_en        = 1'b1;
         im_addr      = bus.branchtarget_i;
         pc_d         = bus.branchtarget_i + PC_ONE;
         pending_d    = 1'b1;
         pending_pc_d = bus.branchtarget_i;
         skid_clear   = 1'b1;
         inst_d       = NOP_INST;
         valid_d      = 1'b0;
         state_d      = ST_RUN;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               issue   = 1'b1;
               state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!bus.stall_i) begin
                  issue = 1'b1;
                  if (pending_q) begin
                     inst_d   = bus.im_data_i;
                     pc_out_d = pending_pc_q;
                     valid_d  = 1'b1;
                  end
               end else begin
                  // The read returning this cycle has nowhere to go: park it.
                  skid_load = pending_q;
                  pending_d = 1'b0;
                  state_d   = ST_STALL;
               end
            end
            ST_STALL: begin
               if (!bus.stall_i) begin
                  if (skid_valid) begin
                     inst_d     = skid_word;
                     pc_out_d   = skid_pc;
                     valid_d    = 1'b1;
                     skid_clear = 1'b1;
                  end
                  // pc_q already points past the parked word, so this fetch
                  // lands on the cycle right behind it: no gap, no repeat.
                  issue   = 1'b1;
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (issue) begin
            im_en        = 1'b1;
            im_addr      = pc_q;
            pc_d         = pc_q + PC_ONE;
            pending_d    = 1'b1;
            pending_pc_d = pc_q;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the values from before this edge regardless of order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         pending_q    <= 1'b0;
         pending_pc_q <= '0;
         inst_q       <= NOP_INST;
         pc_out_q     <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pending_q    <= pending_d;
         pending_pc_q <= pending_pc_d;
         inst_q       <= inst_d;
         pc_out_q     <= pc_out_d;
         valid_q      <= valid_d;
      end
   end

   // The FSM sits in IDLE during reset, which would otherwise request a read;
   // gating with rst keeps the memory quiet until reset is released.
   assign bus.im_en_o   = im_en & rst;
   assign bus.im_addr_o = im_addr;
   assign bus.inst_o    = inst_q;
   assign bus.pc_o      = pc_out_q;
   assign bus.valid_o   = valid_q;

endmodule
